// File: rtl/main_vc_scheduler.sv
// main_vc_scheduler: sequences main FIFO pops and steers each popped word to VC0 or VC1
// Inputs : init/afmf_in/aemf_in configure the thresholds; fifo_empty_main, fifo_error_main and
//          data_main come from the main FIFO; pause_vcX and error_vcX come from the VC FIFOs.
// Outputs: afmf/aemf latched thresholds, pop_main to the main FIFO, push_vcX and data_vc to the
//          VC FIFOs, state plus idle_out/error_out status.
module main_vc_scheduler #(
  parameter int DATA_SIZE  = 6,
  parameter int VC_SEL_BIT = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [DATA_SIZE-1:0] afmf_in,
  input  logic [DATA_SIZE-1:0] aemf_in,
  input  logic                 fifo_empty_main,
  input  logic                 fifo_error_main,
  input  logic [DATA_SIZE-1:0] data_main,
  input  logic                 pause_vc0,
  input  logic                 pause_vc1,
  input  logic                 error_vc0,
  input  logic                 error_vc1,
  output logic [DATA_SIZE-1:0] afmf,
  output logic [DATA_SIZE-1:0] aemf,
  output logic                 pop_main,
  output logic                 push_vc0,
  output logic                 push_vc1,
  output logic [DATA_SIZE-1:0] data_vc,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 error_out
);
  typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
  state_t               state_q;
  logic [DATA_SIZE-1:0] afmf_q, aemf_q;
  logic                 pop_q, err;
  assign err      = fifo_error_main | error_vc0 | error_vc1;
  assign pop_main = state_q == ST_ACTIVE && !fifo_empty_main && !pause_vc0 && !pause_vc1 && !err && !init;
  // The select comes from the registered word itself so it always matches data_vc.
  assign push_vc0  = pop_q & ~data_main[VC_SEL_BIT];
  assign push_vc1  = pop_q & data_main[VC_SEL_BIT];
  assign data_vc   = data_main;
  assign state     = state_q;
  assign afmf      = afmf_q;
  assign aemf      = aemf_q;
  assign idle_out  = state_q == ST_IDLE && fifo_empty_main;
  assign error_out = state_q == ST_ERROR;
  // pop_q keeps running outside ACTIVE so a word popped just before leaving is still pushed.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      afmf_q  <= '0;
      aemf_q  <= '0;
      pop_q   <= 1'b0;
    end else begin
      pop_q <= pop_main;
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          if (init) begin
            afmf_q <= afmf_in;
            aemf_q <= aemf_in;
          end else begin
            state_q <= (afmf_in <= aemf_in) ? ST_ERROR : ST_IDLE;
          end
        end
        ST_IDLE:   state_q <= err ? ST_ERROR : init ? ST_INIT : !fifo_empty_main ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: state_q <= err ? ST_ERROR : init ? ST_INIT : (fifo_empty_main && !pop_q) ? ST_IDLE : ST_ACTIVE;
        ST_ERROR:  state_q <= init ? ST_INIT : ST_ERROR;
        default:   state_q <= ST_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_main_vc_scheduler.sv
// tb_main_vc_scheduler: emulates the main FIFO and checks the scheduler against a cycle model
module tb_main_vc_scheduler;
  logic       clk, reset_L, init;
  logic       fifo_empty_main, fifo_error_main, pause_vc0, pause_vc1, error_vc0, error_vc1;
  logic [5:0] afmf_in, aemf_in, data_main, afmf, aemf, data_vc;
  logic       pop_main, push_vc0, push_vc1, idle_out, error_out;
  logic [2:0] state;
  int mq[$];
  int ms, ma, me, mw, mpd, exp_pop, pop_seen, n_tests, n_fail;

  main_vc_scheduler #(.DATA_SIZE(6), .VC_SEL_BIT(4)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .afmf_in(afmf_in), .aemf_in(aemf_in),
    .fifo_empty_main(fifo_empty_main), .fifo_error_main(fifo_error_main), .data_main(data_main),
    .pause_vc0(pause_vc0), .pause_vc1(pause_vc1), .error_vc0(error_vc0), .error_vc1(error_vc1),
    .afmf(afmf), .aemf(aemf), .pop_main(pop_main), .push_vc0(push_vc0), .push_vc1(push_vc1),
    .data_vc(data_vc), .state(state), .idle_out(idle_out), .error_out(error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rst_check();
    chk("rst_state", int'(state), 0);
    chk("rst_pop", int'(pop_main), 0);
    chk("rst_push0", int'(push_vc0), 0);
    chk("rst_push1", int'(push_vc1), 0);
    chk("rst_idle", int'(idle_out), 0);
    chk("rst_error", int'(error_out), 0);
    chk("rst_afmf", int'(afmf), 0);
    chk("rst_aemf", int'(aemf), 0);
  endtask

  // One clock: check outputs at the falling edge, then advance model and FIFO after the rising edge.
  task automatic cycle();
    int merr;
    fifo_empty_main = (mq.size() == 0);
    @(negedge clk);
    merr = int'(fifo_error_main | error_vc0 | error_vc1);
    exp_pop = int'(ms == 3 && !fifo_empty_main && !pause_vc0 && !pause_vc1 && merr == 0 && !init);
    chk("state", int'(state), ms);
    chk("pop", int'(pop_main), exp_pop);
    chk("push0", int'(push_vc0), int'(mpd != 0 && mw[4] == 1'b0));
    chk("push1", int'(push_vc1), int'(mpd != 0 && mw[4] == 1'b1));
    if (mpd != 0) chk("data_vc", int'(data_vc), mw);
    chk("idle", int'(idle_out), int'(ms == 2 && fifo_empty_main));
    chk("error", int'(error_out), int'(ms == 4));
    chk("afmf", int'(afmf), ma);
    chk("aemf", int'(aemf), me);
    pop_seen = int'(pop_main);
    @(posedge clk);
    #1;
    case (ms)
      0: ms = 1;
      1: if (init) begin ma = int'(afmf_in); me = int'(aemf_in); end
         else ms = (afmf_in <= aemf_in) ? 4 : 2;
      2: ms = merr != 0 ? 4 : init ? 1 : !fifo_empty_main ? 3 : 2;
      3: ms = merr != 0 ? 4 : init ? 1 : (fifo_empty_main && mpd == 0) ? 2 : 3;
      default: ms = init ? 1 : 4;
    endcase
    mpd = exp_pop;
    if (pop_seen != 0 && mq.size() > 0) begin
      mw = mq.pop_front();
      data_main = 6'(mw);
    end
  endtask

  task automatic run_until_pop();
    pop_seen = 0;
    for (int i = 0; i < 20 && pop_seen == 0; i++) cycle();
    chk("pop_seen", pop_seen, 1);
  endtask

  task automatic do_init(input int a, input int e);
    afmf_in = 6'(a);
    aemf_in = 6'(e);
    init = 1'b1;
    repeat (2) cycle();
    init = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic set_rand();
    pause_vc0 = ($urandom_range(0, 3) == 0);
    pause_vc1 = ($urandom_range(0, 3) == 0);
    fifo_error_main = ms >= 2 && $urandom_range(0, 80) == 0;
    error_vc0 = ms >= 2 && $urandom_range(0, 80) == 0;
    error_vc1 = ms >= 2 && $urandom_range(0, 80) == 0;
    init = ms == 4 ? $urandom_range(0, 4) == 0 : ms == 1 ? $urandom_range(0, 1) == 0 : $urandom_range(0, 40) == 0;
    aemf_in = 6'($urandom_range(0, 15));
    afmf_in = $urandom_range(0, 9) == 0 ? aemf_in : 6'($urandom_range(0, 63));
    if ($urandom_range(0, 2) == 0 && mq.size() < 8) mq.push_back(int'($urandom_range(0, 63)));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    ms = 0; ma = 0; me = 0; mw = 0; mpd = 0;
    reset_L = 1'b0; init = 1'b0; afmf_in = '0; aemf_in = '0; data_main = '0;
    fifo_empty_main = 1'b1; fifo_error_main = 1'b0;
    pause_vc0 = 1'b0; pause_vc1 = 1'b0; error_vc0 = 1'b0; error_vc1 = 1'b0;
    @(posedge clk);
    #1;
    rst_check();
    reset_L = 1'b1;
    cycle();
    do_init(5, 1);
    cycle();
    // invalid configuration: one-cycle init pulse with equal thresholds
    afmf_in = 6'd2; aemf_in = 6'd2; init = 1'b1;
    cycle();
    init = 1'b0;
    repeat (3) cycle();
    do_init(40, 3);
    // two words steered to VC1 then VC0
    mq.push_back(8'h13); mq.push_back(8'h05);
    repeat (7) cycle();
    // pause on VC0 blocks every pop
    mq.push_back(8'h11); mq.push_back(8'h22); mq.push_back(8'h0a);
    pause_vc0 = 1'b1;
    repeat (4) cycle();
    pause_vc0 = 1'b0;
    repeat (7) cycle();
    // error arriving right after a pop
    mq.push_back(8'h3f); mq.push_back(8'h01);
    run_until_pop();
    fifo_error_main = 1'b1;
    cycle();
    fifo_error_main = 1'b0;
    repeat (3) cycle();
    do_init(40, 3);
    repeat (4) cycle();
    // asynchronous reset while a push is in flight
    mq.push_back(8'h15); mq.push_back(8'h06);
    run_until_pop();
    chk("inflight_push", int'(push_vc0 | push_vc1), 1);
    reset_L = 1'b0;
    #1;
    rst_check();
    ms = 0; ma = 0; me = 0; mpd = 0;
    reset_L = 1'b1;
    cycle();
    do_init(5, 1);
    for (int i = 0; i < 400; i++) begin
      set_rand();
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
